wb_arbiter2: RTL and testbench

- Two-master Wishbone arbiter that shares the single system bus between master 0 (CPU) and master 1 (DMA controller).
- Sits between the masters and the address-decode/slave mux.
- Grants one master per bus cycle (CYC), using round-robin or fixed priority.
- Holds the grant for bursts.
- A watchdog terminates strobes that are never acknowledged (e.g. unmapped addresses), so a master cannot hang the bus.

---
 rtl/wb_arbiter2.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter2.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master Wishbone arbiter with burst hold and strobe watchdog
module wb_arbiter2 #(
    parameter int unsigned PRIORITY_MODE  = 0,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_DATA   = 32'hFFFF_FFFF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rstn_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m0_dat_o,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m0_we_i,
    input  logic        m1_we_i,
    input  logic        m0_stb_i,
    input  logic        m1_stb_i,
    input  logic        m0_cyc_i,
    input  logic        m1_cyc_i,
    output logic        m0_ack_o,
    output logic        m1_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o,
    output logic        timeout_sticky_o
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] WD_LIMIT = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, BUSY0, BUSY1} state_t;

    state_t        state, state_nxt;
    logic          last_gnt, last_gnt_nxt;   // 1 = master 1 owned the bus last
    logic [CW-1:0] wd_cnt, wd_cnt_nxt;
    logic          forced_ack, forced_nxt;
    logic          timeout_sticky;
    logic          own_cyc, own_stb;

    assign own_cyc = (state == BUSY1) ? m1_cyc_i : m0_cyc_i;
    assign own_stb = (state == BUSY1) ? m1_stb_i : m0_stb_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rstn_i) begin
            state          <= IDLE;
            last_gnt       <= 1'b1;
            wd_cnt         <= '0;
            forced_ack     <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_gnt   <= last_gnt_nxt;
            wd_cnt     <= wd_cnt_nxt;
            forced_ack <= forced_nxt;
            if (forced_nxt) begin
                timeout_sticky <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        wd_cnt_nxt   = '0;
        forced_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_nxt = (PRIORITY_MODE != 0 || last_gnt) ? BUSY0 : BUSY1;
                end else if (m0_cyc_i) begin
                    state_nxt = BUSY0;
                end else if (m1_cyc_i) begin
                    state_nxt = BUSY1;
                end
            end
            BUSY0, BUSY1: begin
                if (!own_cyc) begin
                    state_nxt    = IDLE;
                    last_gnt_nxt = (state == BUSY1);
                end else if (own_stb && !s_ack_i && !forced_ack && TIMEOUT_CYCLES != 0) begin
                    // A real ack in the limit cycle takes the other branch and wins.
                    if (wd_cnt == WD_LIMIT) begin
                        forced_nxt = 1'b1;
                    end else begin
                        wd_cnt_nxt = wd_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = 1'b0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        gnt_o    = 2'b00;
        if (state == BUSY0) begin
            s_we_o   = m0_we_i;
            s_cyc_o  = m0_cyc_i;
            s_stb_o  = m0_stb_i & ~forced_ack;
            // Slave acks during a forced cycle are swallowed by the forced ack.
            m0_ack_o = m0_stb_i & (forced_ack | s_ack_i);
            gnt_o    = 2'b01;
            if (forced_ack) begin
                m0_dat_o = TIMEOUT_DATA;
            end
        end else if (state == BUSY1) begin
            s_adr_o  = m1_adr_i;
            s_dat_o  = m1_dat_i;
            s_sel_o  = m1_sel_i;
            s_we_o   = m1_we_i;
            s_cyc_o  = m1_cyc_i;
            s_stb_o  = m1_stb_i & ~forced_ack;
            m1_ack_o = m1_stb_i & (forced_ack | s_ack_i);
            gnt_o    = 2'b10;
            if (forced_ack) begin
                m1_dat_o = TIMEOUT_DATA;
            end
        end
    end

    assign timeout_o        = forced_ack;
    assign timeout_sticky_o = timeout_sticky;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - scoreboard bench for wb_arbiter2 (round-robin and fixed-priority instances)
module tb_wb_arbiter2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        mc[2], ms[2], mwe[2];
    logic [31:0] madr[2], mdat[2];
    logic [3:0]  msel[2];
    logic [31:0] sdat;
    logic        sack;

    logic [31:0] d_m0_dat[2], d_m1_dat[2], d_s_adr[2], d_s_dat[2];
    logic [3:0]  d_s_sel[2];
    logic        d_m0_ack[2], d_m1_ack[2], d_s_we[2], d_s_stb[2], d_s_cyc[2];
    logic        d_tmo[2], d_sticky[2];
    logic [1:0]  d_gnt[2];

    for (genvar d = 0; d < 2; d++) begin : g_dut
        wb_arbiter2 #(.PRIORITY_MODE(d), .TIMEOUT_CYCLES(8), .TIMEOUT_DATA(32'hFFFF_FFFF)) u_dut (
            .wb_clk_i(clk), .wb_rstn_i(rstn),
            .m0_adr_i(madr[0]), .m1_adr_i(madr[1]),
            .m0_dat_i(mdat[0]), .m1_dat_i(mdat[1]),
            .m0_dat_o(d_m0_dat[d]), .m1_dat_o(d_m1_dat[d]),
            .m0_sel_i(msel[0]), .m1_sel_i(msel[1]),
            .m0_we_i(mwe[0]), .m1_we_i(mwe[1]),
            .m0_stb_i(ms[0]), .m1_stb_i(ms[1]),
            .m0_cyc_i(mc[0]), .m1_cyc_i(mc[1]),
            .m0_ack_o(d_m0_ack[d]), .m1_ack_o(d_m1_ack[d]),
            .s_adr_o(d_s_adr[d]), .s_dat_o(d_s_dat[d]), .s_dat_i(sdat),
            .s_sel_o(d_s_sel[d]), .s_we_o(d_s_we[d]), .s_stb_o(d_s_stb[d]),
            .s_cyc_o(d_s_cyc[d]), .s_ack_i(sack), .gnt_o(d_gnt[d]),
            .timeout_o(d_tmo[d]), .timeout_sticky_o(d_sticky[d])
        );
    end

    typedef struct {
        int          m;
        logic [31:0] data;
        logic        tmo;
    } exp_t;

    exp_t       ack_q[$];
    logic [1:0] gnt_q[$];
    int         checks = 0;
    int         errors = 0;
    int         act = 0;
    bit         mon_on = 1'b0;
    logic [1:0] prev_g = 2'b00;

    task automatic fail(input string name, input logic [31:0] got, input logic [31:0] exp);
        errors++;
        $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) fail(name, got, exp);
    endtask

    // Monitor: acks and grant changes of the active instance are matched against the queues.
    initial begin
        logic       a0, a1;
        logic [1:0] g;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (mon_on) begin
                a0 = d_m0_ack[act];
                a1 = d_m1_ack[act];
                if (a0 && a1) begin
                    checks++;
                    fail("dual_ack", {30'd0, a1, a0}, 32'd0);
                end else if (a0 || a1) begin
                    if (ack_q.size() == 0) begin
                        checks++;
                        fail("ack_unexpected", {30'd0, a1, a0}, 32'd0);
                    end else begin
                        e = ack_q.pop_front();
                        chk("ack_master", a1 ? 32'd1 : 32'd0, e.m);
                        chk("ack_data", a1 ? d_m1_dat[act] : d_m0_dat[act], e.data);
                        chk("ack_timeout", d_tmo[act], e.tmo);
                    end
                end
                g = d_gnt[act];
                if (g != 2'b00 && g != prev_g) begin
                    if (prev_g != 2'b00) begin
                        checks++;
                        fail("gnt_no_idle_gap", g, prev_g);
                    end
                    if (gnt_q.size() == 0) begin
                        checks++;
                        fail("gnt_unexpected", g, 32'd0);
                    end else begin
                        chk("gnt", g, gnt_q.pop_front());
                    end
                end
                prev_g = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic req(input int m, input logic [31:0] a, input logic we);
        mc[m] = 1'b1;
        ms[m] = 1'b1;
        madr[m] = a;
        mwe[m] = we;
        mdat[m] = a ^ 32'h5A5A_0000;
        msel[m] = 4'hF;
    endtask

    task automatic drop(input int m);
        mc[m] = 1'b0;
        ms[m] = 1'b0;
    endtask

    task automatic ack_beat(input int m, input logic [31:0] rd, input logic tmo);
        ack_q.push_back('{m: m, data: rd, tmo: tmo});
        sack = 1'b1;
        sdat = rd;
        tick();
        sack = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_limit: got no finish, expected finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        sack = 1'b0;
        sdat = '0;
        for (int m = 0; m < 2; m++) begin
            drop(m);
            madr[m] = '0;
            mdat[m] = '0;
            msel[m] = '0;
            mwe[m]  = 1'b0;
        end
        do_reset();
        mon_on = 1'b1;
        neg();
        chk("rst_gnt", d_gnt[0], 2'b00);
        chk("rst_cyc", d_s_cyc[0], 0);
        chk("rst_stb", d_s_stb[0], 0);
        chk("rst_tmo", d_tmo[0], 0);
        chk("rst_sticky", d_sticky[0], 0);

        // 1: single requests, m0 read then m1 write
        for (int m = 0; m < 2; m++) begin
            tick();
            gnt_q.push_back(m == 0 ? 2'b01 : 2'b10);
            req(m, 32'h10 + 32'(m * 16), m[0]);
            neg();
            chk("t1_cyc_delay", d_s_cyc[0], 0);
            tick();
            neg();
            chk("t1_cyc_up", d_s_cyc[0], 1);
            chk("t1_adr", d_s_adr[0], 32'h10 + 32'(m * 16));
            chk("t1_we", d_s_we[0], m);
            chk("t1_wdat", d_s_dat[0], (32'h10 + 32'(m * 16)) ^ 32'h5A5A_0000);
            tick();
            tick();
            ack_beat(m, 32'hA5A5_0010 + 32'(m), 1'b0);
            drop(m);
            tick();
            neg();
            chk("t1_release", d_s_cyc[0], 0);
        end

        // 2: round-robin ties, last owner was m1
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        gnt_q.push_back(2'b01);
        tick();
        req(0, 32'h100, 1'b0);
        req(1, 32'h200, 1'b0);
        neg();
        chk("t2_idle", d_s_cyc[0], 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            ack_beat(k % 2, 32'hC000_0000 + 32'(k), 1'b0);
            drop(k % 2);
            if (k == 2) drop(1);
            tick();
            if (k < 2) req(k % 2, 32'h300 + 32'(k), 1'b0);
            neg();
            chk("t2_gap", d_s_cyc[0], 0);
        end

        // 4: watchdog forced termination, late slave ack ignored
        tick();
        gnt_q.push_back(2'b01);
        req(0, 32'h3000_0000, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) begin
            neg();
            chk("t4_stb_wait", d_s_stb[0], 1);
            chk("t4_tmo_low", d_tmo[0], 0);
            tick();
        end
        ack_q.push_back('{m: 0, data: 32'hFFFF_FFFF, tmo: 1'b1});
        sack = 1'b1;
        sdat = 32'h1111_2222;
        neg();
        chk("t4_tmo_pulse", d_tmo[0], 1);
        chk("t4_sticky", d_sticky[0], 1);
        chk("t4_stb_forced", d_s_stb[0], 0);
        tick();
        sack = 1'b0;
        madr[0] = 32'h0000_0100;
        neg();
        chk("t4_tmo_one_cycle", d_tmo[0], 0);
        chk("t4_sticky_hold", d_sticky[0], 1);
        chk("t4_gnt_hold", d_gnt[0], 2'b01);
        tick();
        ack_beat(0, 32'h1234_5678, 1'b0);
        drop(0);
        tick();
        neg();

        // 5: slave ack in the limit cycle wins
        tick();
        gnt_q.push_back(2'b01);
        req(0, 32'h3000_0004, 1'b0);
        tick();
        for (int i = 1; i <= 7; i++) tick();
        ack_beat(0, 32'h5555_AAAA, 1'b0);
        neg();
        chk("t5_no_tmo", d_tmo[0], 0);
        tick();
        drop(0);
        tick();
        neg();

        // 6: reset during an m1 burst, then a tie goes to m0
        tick();
        gnt_q.push_back(2'b10);
        req(1, 32'h50, 1'b0);
        tick();
        ack_beat(1, 32'h0000_0050, 1'b0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        req(0, 32'h60, 1'b0);
        gnt_q.push_back(2'b01);
        neg();
        chk("t6_gnt", d_gnt[0], 2'b00);
        chk("t6_cyc", d_s_cyc[0], 0);
        chk("t6_stb", d_s_stb[0], 0);
        chk("t6_ack0", d_m0_ack[0], 0);
        chk("t6_ack1", d_m1_ack[0], 0);
        chk("t6_sticky", d_sticky[0], 0);
        tick();
        ack_beat(0, 32'h6060_6060, 1'b0);
        drop(0);
        drop(1);
        tick();
        neg();

        // 3: fixed priority instance, burst hold then m0 always wins ties
        tick();
        do_reset();
        act = 1;
        gnt_q.push_back(2'b10);
        req(1, 32'h40, 1'b0);
        tick();
        for (int b = 0; b < 4; b++) begin
            if (b == 1) req(0, 32'h70, 1'b0);
            tick();
            ack_beat(1, 32'hB000_0000 + 32'(b), 1'b0);
        end
        drop(1);
        gnt_q.push_back(2'b01);
        tick();
        neg();
        chk("t3_gap", d_s_cyc[1], 0);
        tick();
        ack_beat(0, 32'h7070_7070, 1'b0);
        drop(0);
        tick();
        for (int k = 0; k < 2; k++) begin
            gnt_q.push_back(2'b01);
            req(0, 32'h80, 1'b0);
            req(1, 32'h90, 1'b0);
            tick();
            ack_beat(0, 32'hD000_0000 + 32'(k), 1'b0);
            drop(0);
            drop(1);
            tick();
        end

        tick();
        tick();
        chk("ack_q_drained", ack_q.size(), 0);
        chk("gnt_q_drained", gnt_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
